jtdsp16_ram: RTL and testbench
==============================

Name: jtdsp16_ram

Overview:
- Internal data RAM of the DSP16; the responder at the far end of the YAAU address bus.
- Serves DSP reads and writes on ph1 cycles at the 11-bit address driven by the RAM address unit.
- Serves a host/debug access port on non-ph1 cycles through a req/ack handshake.
- Optionally clears the whole array after reset, sweeping one word per clock.

Parameters:
AW, 11, address width; depth is 2**AW words
DW, 16, data width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ph1  in  1  DSP phase enable; DSP accesses occur only on clk edges with ph1=1
addr  in  AW  DSP address (YAAU ram_addr)
we  in  1  DSP write enable, sampled with ph1
din  in  DW  DSP write data
dout  out  DW  DSP read data, registered
host_req  in  1  host access request; host holds it high until host_ack
host_we  in  1  host write (1) / read (0); held stable with host_req
host_addr  in  AW  host address; held stable with host_req
host_din  in  DW  host write data; held stable with host_req
host_dout  out  DW  host read data, valid while host_ack=1
host_ack  out  1  one-cycle access-complete pulse
ready  out  1  1 once the array is usable (clear sweep done)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high: it takes effect only at a clk edge where rst=1.
- Reset values: dout=0, host_dout=0, host_ack=0, ready=0. FSM enters CLR (feature built in) or RUN one cycle later (feature absent). Array contents are not reset by rst itself.
- FSM states: CLR, RUN.
- CLR state:
  - Counter cnt starts at 0; mem[cnt]<=0 on every clk, independent of ph1; cnt increments.
  - When cnt reaches 2**AW-1, that word is written, then the FSM moves to RUN. ready=1 on the following cycle, so ready rises 2**AW cycles after rst drops.
  - All DSP accesses are ignored; dout holds 0.
  - host_req is not served; host_ack stays 0 and the request waits.
- rst asserted mid-sweep: cnt returns to 0, ready=0, and the sweep restarts from the beginning.
- DSP port (RUN, ph1=1 edge):
  - we=1: mem[addr]<=din and dout<=din (write-through; new data is visible).
  - we=0: dout<=mem[addr].
  - dout holds its value on all other cycles.
  - Read latency: data is valid after the ph1 edge, ahead of the next ph1.
- Host port (RUN):
  - An access starts on a clk edge where ph1=0, host_req=1 and host_ack=0.
  - Write: mem[host_addr]<=host_din and host_dout<=host_din.
  - Read: host_dout<=mem[host_addr].
  - host_ack=1 for exactly the next cycle.
  - No access starts in a cycle where host_ack=1. If host_req is still high afterwards, a new access starts at the next eligible ph1=0 edge, so the minimum spacing between accesses is 2 cycles.
  - If host_req=1 and ph1=1, the host waits; the DSP always has priority.
- Simultaneous events: DSP and host never touch the array on the same edge, because ph1 gates them apart. A host write followed by a DSP read of the same address on the next ph1 returns the host data.
- host_dout holds its last value when host_ack=0.
- Addresses wrap naturally within AW bits; no out-of-range handling.
- Storage: one write port and one read port per edge, inferable as block RAM with a registered output.

Optional Feature:
- Macro: JTDSP16_RAM_CLR_EN.
- Defined: the CLR state and cnt exist, with behaviour as above.
- Undefined:
  - No CLR state, no counter.
  - FSM enters RUN directly; ready=1 on the first cycle after rst drops.
  - Array power-up contents are unspecified; the bench must write before it reads.

Test Plan:
- Reset/clear (macro on): hold rst 4 cycles, release → ready=0 for 2048 cycles, then 1; DSP reads of addresses 0, 1023 and 2047 return 0; dout=0 throughout CLR.
- DSP write/read: ph1 toggling every other cycle; write 16'hA5C3 at addr 11'h07F with we=1 → dout=16'hA5C3 after the same ph1 edge; next ph1 read of 11'h07F → 16'hA5C3; read of 11'h080 → 16'h0000.
- Host read: DSP previously wrote 16'h1234 at 11'h200; host_req=1, host_we=0, host_addr=11'h200 raised on a ph1=1 cycle → access waits for ph1=0; host_ack pulses one cycle with host_dout=16'h1234.
- Host write then DSP read: host writes 16'hBEEF to 11'h3FF → ack pulse; next ph1 DSP read of 11'h3FF returns 16'hBEEF; host_req held high with ph1=0 every cycle → acks spaced 2 cycles apart.
- Reset mid-sweep: assert rst at cnt=500 for 1 cycle → ready stays 0; ready rises exactly 2048 cycles after rst deassertion; a host request pending during CLR is acked only after ready=1.
- Macro off: ready=1 one cycle after reset release; write then read 16'h0F0F at 11'h000 succeeds with no sweep delay.

Source files
------------

// File: rtl/jtdsp16_ram.sv
// jtdsp16_ram: DSP16 internal data RAM with a ph1-gated DSP port and a req/ack host port.
// Build with JTDSP16_RAM_CLR_EN defined to zero the whole array after reset, one word per clock.
module jtdsp16_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ph1,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic [DW-1:0] host_dout,
    output logic          host_ack,
    output logic          ready
);
    typedef enum logic {CLR, RUN} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] dout_reg, host_dout_reg;
    logic          ready_reg, host_ack_reg;
    logic [AW-1:0] clr_addr;

    logic          clr_wr, dsp_go, host_go, wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

`ifdef JTDSP16_RAM_CLR_EN
    logic [AW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLR)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The last word is written on the same edge that leaves CLR.
    always_comb begin
        state_next = state_reg;
        if (state_reg == CLR && cnt_reg == {AW{1'b1}})
            state_next = RUN;
    end

    assign clr_addr = cnt_reg;
`else
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = RUN;
    end

    assign clr_addr = '0;
`endif

    // ph1 splits the edges between the DSP and the host, so one write port suffices.
    always_comb begin
        clr_wr  = (state_reg == CLR) && !rst;
        dsp_go  = ready_reg && ph1 && !rst;
        host_go = ready_reg && !ph1 && host_req && !host_ack_reg && !rst;
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = din;
        if (clr_wr) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (dsp_go) begin
            wr_en   = we;
        end else if (host_go) begin
            wr_en   = host_we;
            wr_addr = host_addr;
            wr_data = host_din;
        end
        rd_addr = ph1 ? addr : host_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Writes are forwarded straight to the read registers (write-through).
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg      <= '0;
            host_dout_reg <= '0;
            host_ack_reg  <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            ready_reg    <= (state_next == RUN);
            host_ack_reg <= host_go;
            if (dsp_go)
                dout_reg <= we ? din : mem[rd_addr];
            if (host_go)
                host_dout_reg <= host_we ? host_din : mem[rd_addr];
        end
    end

    assign dout      = dout_reg;
    assign host_dout = host_dout_reg;
    assign host_ack  = host_ack_reg;
    assign ready     = ready_reg;
endmodule

// File: tb/tb_jtdsp16_ram.sv
// tb_jtdsp16_ram: directed scoreboard bench for jtdsp16_ram.
// Expectations follow JTDSP16_RAM_CLR_EN the same way the design does.
module tb_jtdsp16_ram;
    localparam int AW = 11;
    localparam int DW = 16;
`ifdef JTDSP16_RAM_CLR_EN
    localparam int READY_LAT = 2048;
`else
    localparam int READY_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, ph1, we, host_req, host_we;
    logic [AW-1:0] addr, host_addr;
    logic [DW-1:0] din, host_din;
    logic [DW-1:0] dout, host_dout;
    logic          host_ack, ready;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [int];

    jtdsp16_ram #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .ph1(ph1), .addr(addr), .we(we), .din(din), .dout(dout),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .host_dout(host_dout), .host_ack(host_ack), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mget(input logic [AW-1:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : '0;
    endfunction

    // One ph1 edge followed by one idle edge, over which dout must hold.
    task automatic dsp_cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        @(negedge clk);
        ph1 = 1'b1; we = w; addr = a; din = d;
        e = w ? d : mget(a);
        if (w) model[int'(a)] = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk(w ? "dsp_wr_through" : "dsp_rd", dout, exp_q.pop_front());
        @(negedge clk);
        ph1 = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("dsp_dout_hold", dout, e);
        $display("dsp %s addr=%h data=%h dout=%h", w ? "wr" : "rd", a, d, dout);
    endtask

    task automatic host_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic on_ph1);
        logic [DW-1:0] e;
        int n;
        @(negedge clk);
        host_req = 1'b1; host_we = w; host_addr = a; host_din = d; ph1 = on_ph1; we = 1'b0;
        e = w ? d : mget(a);
        if (w) model[int'(a)] = d;
        exp_q.push_back(e);
        if (on_ph1) begin
            @(posedge clk); #1;
            chk("host_wait_ph1", host_ack, 0);
            @(negedge clk);
            ph1 = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!host_ack && n < 4000);
        chk("host_ack", host_ack, 1);
        chk("host_dout", host_dout, exp_q.pop_front());
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk); #1;
        chk("host_ack_pulse", host_ack, 0);
        chk("host_dout_hold", host_dout, e);
        $display("host %s addr=%h data=%h host_dout=%h", w ? "wr" : "rd", a, d, host_dout);
    endtask

    initial begin
        int n;
        logic bad;
        logic [7:0] seq;
        logic [7:0] seq_exp;

        rst = 1'b1; ph1 = 1'b0; we = 1'b0; addr = '0; din = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_host_dout", host_dout, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_ready", ready, 0);

        // Release reset while hammering the DSP port with writes that must be ignored.
        @(negedge clk);
        rst = 1'b0; ph1 = 1'b1; we = 1'b1; addr = '0; din = '1;
        n = 0; bad = 1'b0;
        while (!ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (dout !== '0) bad = 1'b1;
            @(negedge clk);
            ph1 = ~ph1;
        end
        ph1 = 1'b0; we = 1'b0;
        chk("ready_latency", n, READY_LAT);
        chk("dout_zero_while_clearing", bad, 0);
        $display("reset release ready after %0d cycles", n);

`ifdef JTDSP16_RAM_CLR_EN
        dsp_cycle(1'b0, 11'h000, '0);
        dsp_cycle(1'b0, 11'h3FF, '0);
        dsp_cycle(1'b0, 11'h7FF, '0);
`else
        dsp_cycle(1'b1, 11'h000, 16'h0F0F);
        dsp_cycle(1'b0, 11'h000, '0);
        dsp_cycle(1'b1, 11'h080, 16'h0000);
`endif

        dsp_cycle(1'b1, 11'h07F, 16'hA5C3);
        dsp_cycle(1'b0, 11'h07F, '0);
        dsp_cycle(1'b0, 11'h080, '0);

        dsp_cycle(1'b1, 11'h200, 16'h1234);
        host_op(1'b0, 11'h200, '0, 1'b1);

        host_op(1'b1, 11'h3FF, 16'hBEEF, 1'b0);
        dsp_cycle(1'b0, 11'h3FF, '0);

        // Held request with ph1 low every cycle: acks every other cycle.
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h3FF; ph1 = 1'b0;
        seq = '0;
        seq_exp = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seq[7-i] = host_ack;
            if (host_ack) chk("host_burst_dout", host_dout, mget(11'h3FF));
        end
        chk("host_ack_spacing", seq, seq_exp);
        $display("host burst ack pattern=%b", seq);
        @(negedge clk);
        host_req = 1'b0;

        // Reset again, then interrupt the sweep at cnt=500 with a one-cycle reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_dout", dout, 0);
`ifdef JTDSP16_RAM_CLR_EN
        model.delete();
`endif
        @(negedge clk);
        rst = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 11'h07F;
        exp_q.push_back(mget(11'h07F));
        n = 0; bad = 1'b0;
        while (!ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (host_ack) bad = 1'b1;
        end
        chk("midrst_ready_latency", n, READY_LAT);
        chk("host_ack_before_ready", bad, 0);
        n = 0;
        while (!host_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pending_host_ack", host_ack, 1);
        chk("pending_host_dout", host_dout, exp_q.pop_front());
        $display("mid-sweep reset ready, pending host read data=%h", host_dout);
        @(negedge clk);
        host_req = 1'b0;

        dsp_cycle(1'b1, 11'h000, 16'h0F0F);
        dsp_cycle(1'b0, 11'h000, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
